// File: rtl/spi_master.sv
// SPI master: sends a command packet to one of CHANNELS slaves, then receives a fixed-width response.
// Defining SPI_MASTER_TIMEOUT_EN adds a bounded wait in START/WAIT that ends with o_error.
module spi_master #(
  parameter int  CHANNELS       = 3,
  parameter int  TX_WIDTH       = 40,
  parameter int  RX_WIDTH       = 16,
  parameter int  TIMEOUT_CYCLES = 64,
  localparam int CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int LEN_W          = $clog2(TX_WIDTH + 1)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [CH_W-1:0]     i_channel,
  input  logic [TX_WIDTH-1:0] i_tx_data,
  input  logic [LEN_W-1:0]    i_tx_len,
  output logic                o_ready,
  output logic [RX_WIDTH-1:0] o_rx_data,
  output logic                o_valid,
  output logic                o_error,
  output logic                o_sclk,
  output logic [CHANNELS-1:0] o_nss,
  output logic                o_mosi,
  input  logic                i_miso,
  output logic [5:0]          o_state
);

  // Handshake: a request is taken on a posedge where i_start=1 and o_ready=1; o_ready then
  // stays low until the one-cycle o_valid pulse, which qualifies o_rx_data and o_error.

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_START = 6'b000010,
    S_SEND  = 6'b000100,
    S_WAIT  = 6'b001000,
    S_RECV  = 6'b010000,
    S_DONE  = 6'b100000
  } state_t;

  localparam int MAXW  = (TX_WIDTH > RX_WIDTH) ? TX_WIDTH : RX_WIDTH;
  localparam int CNT_W = $clog2(MAXW + 1);

  localparam logic [LEN_W-1:0] TX_MAX   = LEN_W'(TX_WIDTH);
  localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(CHANNELS);
  localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(RX_WIDTH - 1);

  state_t              state;
  state_t              state_next;
  logic [CH_W-1:0]     ch_q;
  logic [TX_WIDTH-1:0] tx_q;
  logic [CNT_W-1:0]    last_q;
  logic [CNT_W-1:0]    bit_cnt;
  logic [RX_WIDTH-1:0] rx_q;
  logic [RX_WIDTH-1:0] rx_next;
  logic                err_q;
  logic                accept;
  logic                bad_ch;
  logic                busy;
  logic                timeout_hit;
  logic [LEN_W-1:0]    eff_len;

  assign accept  = (state == S_IDLE) && i_start;
  assign bad_ch  = ({1'b0, i_channel} >= CH_LIMIT);
  assign eff_len = ((i_tx_len == '0) || (i_tx_len > TX_MAX)) ? TX_MAX : i_tx_len;
  assign busy    = (state == S_START) || (state == S_SEND) ||
                   (state == S_WAIT)  || (state == S_RECV);
  // Response bits shift in at the top, so after RX_WIDTH samples bit 0 is the first one received.
  assign rx_next = {i_miso, rx_q[RX_WIDTH-1:1]};

`ifdef SPI_MASTER_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if ((state == S_START) || (state == S_WAIT)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
`else
  // No timeout in this build; the parameter stays part of the interface for both builds.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_next = bad_ch ? S_DONE : S_START;
        end
      end
      S_START: begin
        if (!i_miso) begin
          state_next = S_SEND;
        end else if (timeout_hit) begin
          state_next = S_DONE;
        end
      end
      S_SEND: begin
        if (bit_cnt == last_q) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_miso) begin
          state_next = S_RECV;
        end else if (timeout_hit) begin
          state_next = S_DONE;
        end
      end
      S_RECV: begin
        if (bit_cnt == RX_LAST) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      ch_q      <= '0;
      tx_q      <= '0;
      last_q    <= '0;
      bit_cnt   <= '0;
      rx_q      <= '0;
      o_rx_data <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        ch_q   <= i_channel;
        tx_q   <= i_tx_data;
        last_q <= CNT_W'(eff_len - LEN_W'(1));
        err_q  <= bad_ch;
      end else if (state == S_SEND) begin
        tx_q <= tx_q >> 1;
      end

      if (state_next != state) begin
        bit_cnt <= '0;
      end else if ((state == S_SEND) || (state == S_RECV)) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      if (state == S_RECV) begin
        rx_q <= rx_next;
        if (state_next == S_DONE) begin
          o_rx_data <= rx_next;
        end
      end

      // Only a timeout can leave START or WAIT straight for DONE.
      if (((state == S_START) || (state == S_WAIT)) && (state_next == S_DONE)) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    o_nss = '1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (busy && (ch_q == CH_W'(i))) begin
        o_nss[i] = 1'b0;
      end
    end
  end

  always_comb begin
    o_mosi = 1'b0;
    if (state == S_START) begin
      o_mosi = 1'b1;
    end else if (state == S_SEND) begin
      o_mosi = tx_q[0];
    end
  end

  assign o_ready = (state == S_IDLE);
  assign o_valid = (state == S_DONE);
  assign o_error = err_q;
  assign o_sclk  = i_clock;
  assign o_state = state;

endmodule

// File: doc/spi_master.md
# spi_master

Parametrised SPI master that replaces the fixed per-unit SPI sequencing inside the processor. It serialises one command packet to any of `CHANNELS` slave units (ALU, barrel shifter, multiplier, future units). It then waits for the slave's start bit and deserialises a fixed-width response. It has a start/ready/valid handshake on the CPU side, a per-transaction transmit length, and an optional response timeout. The processor's EXECUTE stage starts a transaction and stalls until `o_valid`.

## Interface
Parameters:
- `CHANNELS`, 3: number of slave units; one `nss` line each.
- `TX_WIDTH`, 40: maximum command packet width in bits.
- `RX_WIDTH`, 16: response packet width in bits.
- `TIMEOUT_CYCLES`, 64: maximum WAIT cycles before error (used only with `SPI_MASTER_TIMEOUT_EN`).

Ports:
- `i_clock`  in  1  system clock; also the SPI clock.
- `i_reset`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  request a transaction; accepted only when `o_ready`=1.
- `i_channel`  in  $clog2(CHANNELS)  target slave index.
- `i_tx_data`  in  TX_WIDTH  command packet; bit 0 is sent first.
- `i_tx_len`  in  $clog2(TX_WIDTH+1)  number of bits to send; 0 or >TX_WIDTH means TX_WIDTH.
- `o_ready`  out  1  master idle, able to accept `i_start`.
- `o_rx_data`  out  RX_WIDTH  last received response; bit 0 received first.
- `o_valid`  out  1  one-cycle pulse: transaction finished, `o_rx_data`/`o_error` valid.
- `o_error`  out  1  qualified by `o_valid`: bad channel or timeout.
- `o_sclk`  out  1  equals `i_clock`.
- `o_nss`  out  CHANNELS  active-low slave selects.
- `o_mosi`  out  1  serial data to slaves.
- `i_miso`  in  1  serial data from slaves (wired-OR of idle-low slaves).

## Operation
- States: IDLE, START, SEND, WAIT, RECV, DONE. Use a one-hot encoding.
- Reset values (asynchronous, held while `i_reset`=0):
  - state IDLE; `o_nss`='1; `o_mosi`=0; `o_ready`=1; `o_valid`=0; `o_error`=0; `o_rx_data`=0.
  - All counters and shift registers are 0.
  - Reset mid-transaction aborts it with no `o_valid`.
- IDLE: `o_ready`=1, all `nss` high, `mosi`=0.
  - On `i_start`: latch channel, tx_data, and effective length.
  - If `i_channel`≥CHANNELS, go to DONE with error=1 and `o_rx_data` unchanged.
  - Otherwise go to START.
- START: `nss[ch]`=0, `mosi`=1 (start bit). Stay until `i_miso` is sampled 0, then go to SEND with bit_cnt=0.
- SEND: `mosi`=tx[bit_cnt], `nss[ch]`=0. bit_cnt increments each cycle. After bit len-1 is driven, go to WAIT.
- WAIT: `nss[ch]`=0, `mosi`=0. On `i_miso`=1 (slave start bit), go to RECV with bit_cnt=0.
- RECV: each posedge samples `i_miso` into rx[bit_cnt]. After RX_WIDTH samples, copy rx to `o_rx_data` and go to DONE.
- DONE: `o_valid`=1 for exactly one cycle, all `nss` high. Go to IDLE.
- Only one `nss` bit is ever low at a time. Non-selected lines stay high in every state.
- `i_start` outside IDLE is ignored. No queueing.
- Input changes after acceptance do not affect the transaction in flight.

## Timing
- All transitions are on posedge `i_clock`. Outputs are registered or decoded from state, with no combinational path from `i_start`.
- Start accepted at cycle 0 (IDLE→START at that edge).
- START lasts ≥1 cycle. SEND lasts exactly len cycles. WAIT lasts ≥1 cycle. RECV lasts exactly RX_WIDTH cycles. DONE lasts 1 cycle.
- Minimum start-to-`o_valid` latency: len+RX_WIDTH+3 cycles. This is 59 cycles with defaults, len=40, and an immediately responsive slave.
- Bad channel: `o_valid` is asserted in the cycle after acceptance. `o_ready` returns the cycle after that.
- `o_ready` is 0 from the cycle after acceptance through DONE.
- `o_rx_data` holds its value between transactions. It is not updated on error.

## Configuration
- `SPI_MASTER_TIMEOUT_EN` defined:
  - A wait counter runs in START and in WAIT.
  - If it reaches TIMEOUT_CYCLES, go to DONE with `o_error`=1 and `o_rx_data` unchanged.
  - The counter clears on each state entry.
- `SPI_MASTER_TIMEOUT_EN` undefined: START and WAIT wait indefinitely. `o_error` is set only for a bad channel.

## Test plan
- Channel 0, tx=0x0_0000_A5C3, len=40; slave echoes 0x1234 → `nss`=3'b110 during the transaction; mosi serialises LSB first; `o_valid` with rx=0x1234, error=0, 59 cycles after start.
- Channel 2, len=32; slave returns 0xFFFF after a 5-cycle WAIT → SEND exactly 32 cycles; rx=0xFFFF; `nss[0]` and `nss[1]` stay high throughout.
- `i_channel`=3 with CHANNELS=3 → `o_valid`+`o_error` one cycle after start; `nss` never low; `o_rx_data` keeps its previous value.
- `i_start` pulsed during SEND → ignored; exactly one `o_valid`; the second request is lost.
- `i_reset` low in the middle of RECV → `nss`='1, `mosi`=0, `o_ready`=1 immediately; no `o_valid`; a new transaction after release completes correctly.
- With `SPI_MASTER_TIMEOUT_EN`, a slave that never raises miso → `o_valid`+`o_error` exactly 64 WAIT cycles after entering WAIT; without the macro, the master stays in WAIT with `o_ready`=0.
